// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access
// sizes and the byte-lane patterns that encode them on mem_byte_enable.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } lsu_size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic lsu_size_e decode_size(input logic [3:0] be);
    case (be)
      BE_BYTE: return SZ_BYTE;
      BE_HALF: return SZ_HALF;
      BE_WORD: return SZ_WORD;
      default: return SZ_BAD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: places store data/byte enables on the word bus
// and extracts plus sign/zero-extends the addressed bytes of a read word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  localparam int OFF_W          = $clog2(BYTE_DATA_WIDTH)
) (
  input  lsu_size_e                  st_size,
  input  logic [OFF_W-1:0]           st_offset,
  input  logic [DATA_WIDTH-1:0]      store_data,
  output logic [BYTE_DATA_WIDTH-1:0] st_be,
  output logic [DATA_WIDTH-1:0]      st_wdata,
  input  lsu_size_e                  ld_size,
  input  logic [OFF_W-1:0]           ld_offset,
  input  logic                       ld_unsigned,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic [DATA_WIDTH-1:0]      ld_data
);

  logic [BYTE_DATA_WIDTH-1:0] be_base;
  logic [DATA_WIDTH-1:0]      shifted;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave a latch behind.
    be_base = '0;
    case (st_size)
      SZ_BYTE: be_base = BYTE_DATA_WIDTH'(BE_BYTE);
      SZ_HALF: be_base = BYTE_DATA_WIDTH'(BE_HALF);
      SZ_WORD: be_base = BYTE_DATA_WIDTH'(BE_WORD);
      default: be_base = '0;
    endcase
    st_be    = be_base << st_offset;
    st_wdata = store_data << {st_offset, 3'b000};
  end

  always_comb begin
    shifted = rdata >> {ld_offset, 3'b000};
    ld_data = shifted;
    case (ld_size)
      SZ_BYTE: ld_data = {{(DATA_WIDTH-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = {{(DATA_WIDTH-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: captures one decode request, runs a single word-bus
// transaction with a timeout, and returns extended load data (four-phase).
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_req,
  input  logic                       mem_we,
  input  logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable,
  input  logic                       load_unsigned,
  input  logic [DATA_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      store_data,
  output logic                       mem_valid,
  output logic                       mem_err,
  output logic [DATA_WIDTH-1:0]      load_data,
  output logic                       bus_req,
  output logic                       bus_we,
  output logic [DATA_WIDTH-1:0]      bus_addr,
  output logic [BYTE_DATA_WIDTH-1:0] bus_be,
  output logic [DATA_WIDTH-1:0]      bus_wdata,
  input  logic [DATA_WIDTH-1:0]      bus_rdata,
  input  logic                       bus_ack
);

  localparam int OFF_W = $clog2(BYTE_DATA_WIDTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  lsu_size_e                  size_q, size_d;
  logic [OFF_W-1:0]           off_q, off_d;
  logic                       unsigned_q, unsigned_d;
  logic                       we_q, we_d;
  logic                       err_q, err_d;
  logic [DATA_WIDTH-1:0]      bus_addr_q, bus_addr_d;
  logic [BYTE_DATA_WIDTH-1:0] bus_be_q, bus_be_d;
  logic [DATA_WIDTH-1:0]      bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0]      load_data_q, load_data_d;

  lsu_size_e                  req_size;
  logic [OFF_W-1:0]           req_off;
  logic                       req_bad;
  logic [BYTE_DATA_WIDTH-1:0] req_be;
  logic [DATA_WIDTH-1:0]      req_wdata;
  logic [DATA_WIDTH-1:0]      ld_ext;

  assign req_size = decode_size(mem_byte_enable);
  assign req_off  = addr[OFF_W-1:0];
  assign req_bad  = (req_size == SZ_BAD) || is_misaligned(req_size, req_off);

  lsu_align #(
    .DATA_WIDTH      (DATA_WIDTH),
    .BYTE_DATA_WIDTH (BYTE_DATA_WIDTH)
  ) u_align (
    .st_size     (req_size),
    .st_offset   (req_off),
    .store_data  (store_data),
    .st_be       (req_be),
    .st_wdata    (req_wdata),
    .ld_size     (size_q),
    .ld_offset   (off_q),
    .ld_unsigned (unsigned_q),
    .rdata       (bus_rdata),
    .ld_data     (ld_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    off_d       = off_q;
    unsigned_d  = unsigned_q;
    we_d        = we_q;
    err_d       = err_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    load_data_d = load_data_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          size_d      = req_size;
          off_d       = req_off;
          unsigned_d  = load_unsigned;
          we_d        = mem_we;
          bus_addr_d  = {addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          bus_be_d    = req_be;
          bus_wdata_d = req_wdata;
          cnt_d       = '0;
          err_d       = req_bad;
          state_d     = req_bad ? ST_DONE : ST_BUS;
        end
      end
      ST_BUS: begin
        // An ack in the final allowed cycle still counts as success.
        if (bus_ack) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          if (!we_q) load_data_d = ld_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!mem_req) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      size_q      <= SZ_BYTE;
      off_q       <= '0;
      unsigned_q  <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      off_q       <= off_d;
      unsigned_q  <= unsigned_d;
      we_q        <= we_d;
      err_q       <= err_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      load_data_q <= load_data_d;
    end
  end

  // Handshake outputs decode from state so reset drops them without a clock.
  assign bus_req   = (state_q == ST_BUS);
  assign bus_we    = bus_req & we_q;
  assign mem_valid = (state_q == ST_DONE);
  assign mem_err   = err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign load_data = load_data_q;

endmodule
